mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the fetch stage (instruction reads) and the MEM stage (data loads and stores).
- Sits between the pipeline stages and the memory/cache interface, with one outstanding transaction at a time.
- Data requests have priority because a MEM stall freezes the whole pipeline. A starvation counter guarantees fetch progress.
- A fetch flush on a taken branch or jump discards the in-flight fetch response.

Parameters:
- STARVE_LIMIT, 4, number of consecutive contested data grants before fetch is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- f_req_valid  in  1  fetch request
- f_req_addr  in  64  fetch address, 4-byte aligned
- f_req_ready  out  1  fetch request accepted this cycle
- f_flush  in  1  discard any outstanding fetch
- f_resp_valid  out  1  instruction valid (one-cycle pulse)
- f_resp_data  out  32  instruction word
- d_req_valid  in  1  data request
- d_req_addr  in  64  data address, 8-byte aligned
- d_req_write  in  1  1 = store
- d_req_wdata  in  64  store data
- d_req_wstrb  in  8  byte enables
- d_req_ready  out  1  data request accepted this cycle
- d_resp_valid  out  1  load data / store ack (one-cycle pulse)
- d_resp_data  out  64  load data; 0 for stores
- mem_req_valid, mem_req_addr(64), mem_req_write, mem_req_wdata(64), mem_req_wstrb(8)  out  memory request
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  memory response
- mem_resp_data  in  64  read data
- busy  out  1  state != ARB_IDLE

Behaviour:
- Reset (rst=0, async): state ARB_IDLE; all valid/ready outputs 0; data outputs 0; starve_cnt 0; drop 0; owner OWN_DATA.
- ARB_IDLE, arbitration and acceptance:
  - Ready outputs are combinational, asserted to the winner only.
  - Data wins unless f_req_valid && starve_cnt == STARVE_LIMIT.
  - f_req_ready is forced 0 when f_flush=1.
  - On accept, latch the request (fetch: write=0, wstrb=0, wdata=0), set owner, go to ARB_ISSUE.
- ARB_ISSUE:
  - mem_req_valid=1 with the latched fields held stable.
  - On mem_req_ready, go to ARB_WAIT.
  - Requesters' ready outputs are 0.
- ARB_WAIT:
  - On mem_resp_valid, the owner's resp_valid pulses the next cycle (registered), then go to ARB_IDLE.
  - A new acceptance is possible in that same IDLE cycle.
- Minimum latency: accept at T, mem_req_valid at T+1; with ready at T+1 and response at T+2, resp_valid at T+3.
- f_resp_data = mem_resp_data[63:32] if latched addr[2]=1, else [31:0].
- d_resp_data = mem_resp_data for loads, 0 for stores.
- Store completion: a store still waits for mem_resp_valid as its ack.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when data is granted while f_req_valid=1.
  - Cleared on any fetch grant.
  - Unchanged on an uncontested data grant.
- Flush:
  - f_flush while owner==OWN_FETCH in ISSUE or WAIT sets drop. The memory transaction still completes; the request is never retracted.
  - The response is consumed and f_resp_valid stays 0. Drop clears on return to IDLE.
  - f_flush with no fetch outstanding has no effect.
  - f_flush in the same cycle as the response pulse: the pulse is suppressed.
- Boundaries:
  - mem_resp_valid outside ARB_WAIT is ignored.
  - Reset mid-transaction abandons it; any late response lands in IDLE and is ignored.
  - Requests deasserted before acceptance are not latched.

Decomposition:
- Package mem_arbiter_types:
  - arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT}
  - arb_owner_e {OWN_FETCH, OWN_DATA}
  - reuse the shared double_word typedef for 64-bit fields
- Single module; winner selection and starve counter stay inline. No sub-module required.

Test Plan:
- Fetch only, addr 0x1004, mem returns 0xAAAA_BBBB_CCCC_DDDD with 0-wait ready -> f_resp_data 0xAAAA_BBBB, f_resp_valid 3 cycles after accept; d_resp_valid never set.
- Simultaneous f/d valid, data load addr 0x2000 -> d_req_ready=1, f_req_ready=0; data served first, then fetch accepted in the following IDLE cycle.
- Fetch and data both held valid continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- Fetch accepted, f_flush pulsed during ARB_WAIT, mem_resp_valid 2 cycles later -> f_resp_valid stays 0, busy drops, next request accepted normally.
- Store addr 0x3008, wdata 0x1122334455667788, wstrb 0xF0, mem_req_ready delayed 3 cycles -> mem_req fields stable for all 4 cycles; d_resp_valid pulse with d_resp_data 0.
- rst asserted during ARB_ISSUE -> mem_req_valid 0 immediately, busy 0; stray mem_resp_valid after release produces no response pulse.

Source files
------------

// File: rtl/mem_arbiter_types_pkg.sv
// ----------------------------------------------------------------------------
// mem_arbiter_types
//   Shared types for the unified memory-port arbiter: the arbiter FSM states,
//   the transaction owner, the 64-bit double_word used for address and data
//   fields, and the width of the fetch starvation counter.
// ----------------------------------------------------------------------------
package mem_arbiter_types;

    typedef logic [63:0] double_word;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_e;

    // Wide enough for the largest legal starvation limit (15).
    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between instruction fetch and the MEM stage, with a
//   single outstanding transaction. Data requests win arbitration unless fetch
//   has lost STARVE_LIMIT consecutive contested grants. A fetch flush drops the
//   in-flight fetch response without retracting the memory request.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   f_req_*             fetch request (valid/addr) and combinational ready
//   f_flush             discard any outstanding fetch
//   f_resp_valid/data   instruction word, one-cycle pulse
//   d_req_*             data request (valid/addr/write/wdata/wstrb), ready
//   d_resp_valid/data   load data or store ack (data 0), one-cycle pulse
//   mem_req_*           memory request, held stable until mem_req_ready
//   mem_resp_valid/data memory response
//   busy                a transaction is in progress
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arbiter_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req_valid,
    input  double_word  f_req_addr,
    output logic        f_req_ready,
    input  logic        f_flush,
    output logic        f_resp_valid,
    output logic [31:0] f_resp_data,
    input  logic        d_req_valid,
    input  double_word  d_req_addr,
    input  logic        d_req_write,
    input  double_word  d_req_wdata,
    input  logic [7:0]  d_req_wstrb,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output double_word  d_resp_data,
    output logic        mem_req_valid,
    output double_word  mem_req_addr,
    output logic        mem_req_write,
    output double_word  mem_req_wdata,
    output logic [7:0]  mem_req_wstrb,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  double_word  mem_resp_data,
    output logic        busy
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    arb_state_e          state;
    arb_owner_e          owner;
    logic [STARVE_W-1:0] starve_cnt;
    logic                drop;
    double_word          lat_addr;
    double_word          lat_wdata;
    logic                lat_write;
    logic [7:0]          lat_wstrb;
    logic                f_resp_pulse;

    logic idle;
    logic f_eligible;
    logic fetch_forced;
    logic grant_d;
    logic grant_f;

    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
        return (v >= LIMIT) ? LIMIT : v + 1'b1;
    endfunction

    // Winner selection: a flushing fetch is never eligible, so data may take
    // the slot even when fetch would otherwise be forced.
    assign idle         = (state == ARB_IDLE);
    assign f_eligible   = f_req_valid && !f_flush;
    assign fetch_forced = f_eligible && (starve_cnt == LIMIT);
    assign grant_d      = idle && d_req_valid && !fetch_forced;
    assign grant_f      = idle && f_eligible && !grant_d;

    assign f_req_ready   = grant_f;
    assign d_req_ready   = grant_d;
    assign mem_req_valid = (state == ARB_ISSUE);
    assign mem_req_addr  = lat_addr;
    assign mem_req_write = lat_write;
    assign mem_req_wdata = lat_wdata;
    assign mem_req_wstrb = lat_wstrb;
    assign busy          = !idle;
    // A flush arriving while the instruction pulse is on the output kills it.
    assign f_resp_valid  = f_resp_pulse && !f_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARB_IDLE;
            owner        <= OWN_DATA;
            starve_cnt   <= '0;
            drop         <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_write    <= 1'b0;
            lat_wstrb    <= '0;
            f_resp_pulse <= 1'b0;
            f_resp_data  <= '0;
            d_resp_valid <= 1'b0;
            d_resp_data  <= '0;
        end else begin
            f_resp_pulse <= 1'b0;
            d_resp_valid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        lat_addr  <= d_req_addr;
                        lat_write <= d_req_write;
                        lat_wdata <= d_req_wdata;
                        lat_wstrb <= d_req_wstrb;
                        owner     <= OWN_DATA;
                        state     <= ARB_ISSUE;
                        // Only a contested data grant counts against fetch.
                        if (f_req_valid) starve_cnt <= sat_inc(starve_cnt);
                    end else if (grant_f) begin
                        lat_addr   <= f_req_addr;
                        lat_write  <= 1'b0;
                        lat_wdata  <= '0;
                        lat_wstrb  <= '0;
                        owner      <= OWN_FETCH;
                        state      <= ARB_ISSUE;
                        starve_cnt <= '0;
                    end
                end
                ARB_ISSUE: begin
                    if (mem_req_ready) state <= ARB_WAIT;
                    if (owner == OWN_FETCH && f_flush) drop <= 1'b1;
                end
                ARB_WAIT: begin
                    if (mem_resp_valid) begin
                        state <= ARB_IDLE;
                        drop  <= 1'b0;
                        if (owner == OWN_FETCH) begin
                            // The response is consumed either way; only the
                            // pulse is withheld for a flushed fetch.
                            f_resp_pulse <= !(drop || f_flush);
                            f_resp_data  <= lat_addr[2] ? mem_resp_data[63:32]
                                                        : mem_resp_data[31:0];
                        end else begin
                            d_resp_valid <= 1'b1;
                            d_resp_data  <= lat_write ? '0 : mem_resp_data;
                        end
                    end else if (owner == OWN_FETCH && f_flush) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (STARVE_LIMIT = 4). The bench plays
//   the memory side itself; expected responses are queued on acceptance and
//   compared by a monitor when the DUT pulses a response.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req_valid;
    logic [63:0] f_req_addr;
    logic        f_req_ready;
    logic        f_flush;
    logic        f_resp_valid;
    logic [31:0] f_resp_data;
    logic        d_req_valid;
    logic [63:0] d_req_addr;
    logic        d_req_write;
    logic [63:0] d_req_wdata;
    logic [7:0]  d_req_wstrb;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [63:0] d_resp_data;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_write;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_f;
        logic [63:0] data;
    } exp_t;
    exp_t sb[$];

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
        .f_flush(f_flush), .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_write(d_req_write),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_write(mem_req_write), .mem_req_wdata(mem_req_wdata),
        .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (f_resp_valid === 1'b1 || d_resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {62'd0, f_resp_valid, d_resp_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_kind", {62'd0, f_resp_valid, d_resp_valid},
                    e.is_f ? 64'd2 : 64'd1);
                if (e.is_f) chk("f_resp_data", {32'd0, f_resp_data}, e.data);
                else        chk("d_resp_data", d_resp_data, e.data);
            end
        end
    end

    // Checks the winner in the current IDLE cycle, queues the expected
    // response if any, and advances past the accepting edge.
    task automatic do_accept(input string tag, input bit is_f, input bit push,
                             input logic [63:0] exp_data);
        #1;
        chk({tag, "_ready"}, {62'd0, f_req_ready, d_req_ready}, is_f ? 64'd2 : 64'd1);
        if (push) sb.push_back('{is_f: is_f, data: exp_data});
        tick();
    endtask

    // Memory side of one transaction, starting in the first ISSUE cycle.
    task automatic serve(input logic [63:0] e_addr, input logic e_write,
                         input logic [63:0] e_wdata, input logic [7:0] e_wstrb,
                         input int rdly, input int wdly, input logic [63:0] rdata,
                         input bit flush_wait, input bit flush_resp);
        for (int i = 0; i <= rdly; i++) begin
            chk("issue_valid", {63'd0, mem_req_valid}, 64'd1);
            chk("issue_addr", mem_req_addr, e_addr);
            chk("issue_write", {63'd0, mem_req_write}, {63'd0, e_write});
            chk("issue_wdata", mem_req_wdata, e_wdata);
            chk("issue_wstrb", {56'd0, mem_req_wstrb}, {56'd0, e_wstrb});
            chk("issue_no_ready", {62'd0, f_req_ready, d_req_ready}, 64'd0);
            mem_req_ready = (i == rdly);
            tick();
        end
        mem_req_ready = 1'b0;
        for (int j = 0; j < wdly; j++) begin
            f_flush = flush_wait && (j == 0);
            chk("wait_busy", {63'd0, busy}, 64'd1);
            chk("wait_no_req", {63'd0, mem_req_valid}, 64'd0);
            tick();
        end
        f_flush        = flush_resp;
        mem_resp_valid = 1'b1;
        mem_resp_data  = rdata;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        f_flush        = 1'b0;
        chk("done_idle", {63'd0, busy}, 64'd0);
    endtask

    logic [9:0] starve_pat;

    initial begin
        rst = 1'b0;
        f_req_valid = 0; f_req_addr = '0; f_flush = 0;
        d_req_valid = 0; d_req_addr = '0; d_req_write = 0; d_req_wdata = '0; d_req_wstrb = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        starve_pat = 10'b1000010000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_resp_valid", {62'd0, f_resp_valid, d_resp_valid}, 64'd0);
        chk("rst_mem_addr", mem_req_addr, 64'd0);
        chk("rst_d_resp_data", d_resp_data, 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Fetch only, upper word, zero-wait memory
        f_req_valid = 1; f_req_addr = 64'h1004;
        do_accept("f1004", 1, 1, 64'hAAAA_BBBB);
        f_req_valid = 0;
        serve(64'h1004, 0, 0, 0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0);
        chk("f1004_pulse_t3", {62'd0, f_resp_valid, d_resp_valid}, 64'd2);

        // Fetch, lower word, one wait cycle each side
        f_req_valid = 1; f_req_addr = 64'h2000;
        do_accept("f2000", 1, 1, 64'hCCCC_DDDD);
        f_req_valid = 0;
        serve(64'h2000, 0, 0, 0, 1, 1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0);

        // Simultaneous fetch and data load: data first, then fetch
        f_req_valid = 1; f_req_addr = 64'h4000;
        d_req_valid = 1; d_req_addr = 64'h2000; d_req_write = 0;
        do_accept("both_d", 0, 1, 64'h0123_4567_89AB_CDEF);
        d_req_valid = 0;
        serve(64'h2000, 0, 0, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 0);
        do_accept("both_f", 1, 1, 64'h5555_6666);
        f_req_valid = 0;
        serve(64'h4000, 0, 0, 0, 0, 0, 64'h7777_8888_5555_6666, 0, 0);

        // Both held continuously: D,D,D,D,F,D,D,D,D,F
        f_req_valid = 1; f_req_addr = 64'h5000;
        d_req_valid = 1; d_req_addr = 64'h2008; d_req_write = 0;
        for (int i = 0; i < 10; i++) begin
            logic [63:0] rd;
            rd = {32'hF000_0000 + i, 32'h0D00_0000 + i};
            if (starve_pat[i]) begin
                do_accept("starve_f", 1, 1, {32'd0, rd[31:0]});
                serve(64'h5000, 0, 0, 0, 0, 0, rd, 0, 0);
            end else begin
                do_accept("starve_d", 0, 1, rd);
                serve(64'h2008, 0, 0, 0, 0, 0, rd, 0, 0);
            end
        end
        f_req_valid = 0; d_req_valid = 0;
        tick();

        // Flush during WAIT, response two cycles later: no pulse
        f_req_valid = 1; f_req_addr = 64'h6000;
        do_accept("flush_wait", 1, 0, 64'd0);
        f_req_valid = 0;
        serve(64'h6000, 0, 0, 0, 0, 2, 64'h1111_2222_3333_4444, 1, 0);
        chk("flush_wait_nopulse", {63'd0, f_resp_valid}, 64'd0);
        d_req_valid = 1; d_req_addr = 64'h2010; d_req_write = 0;
        do_accept("after_flush", 0, 1, 64'h9999_AAAA_BBBB_CCCC);
        d_req_valid = 0;
        serve(64'h2010, 0, 0, 0, 0, 0, 64'h9999_AAAA_BBBB_CCCC, 0, 0);

        // Flush in the cycle the response arrives: pulse suppressed
        f_req_valid = 1; f_req_addr = 64'h7004;
        do_accept("flush_resp", 1, 0, 64'd0);
        f_req_valid = 0;
        serve(64'h7004, 0, 0, 0, 0, 1, 64'hDEAD_BEEF_0000_0000, 0, 1);
        chk("flush_resp_nopulse", {63'd0, f_resp_valid}, 64'd0);

        // Flush with nothing outstanding, then a normal fetch
        f_flush = 1;
        tick();
        f_flush = 0;
        f_req_valid = 1; f_req_addr = 64'h8004;
        do_accept("post_idle_flush", 1, 1, 64'hCAFE_F00D);
        f_req_valid = 0;
        serve(64'h8004, 0, 0, 0, 0, 0, 64'hCAFE_F00D_0000_0001, 0, 0);

        // Store with delayed mem_req_ready; ack carries zero data
        d_req_valid = 1; d_req_addr = 64'h3008; d_req_write = 1;
        d_req_wdata = 64'h1122_3344_5566_7788; d_req_wstrb = 8'hF0;
        do_accept("store", 0, 1, 64'd0);
        d_req_valid = 0; d_req_write = 0; d_req_wdata = '0; d_req_wstrb = '0;
        serve(64'h3008, 1, 64'h1122_3344_5566_7788, 8'hF0, 3, 0,
              64'hFFFF_EEEE_DDDD_CCCC, 0, 0);

        // Stray response while IDLE is ignored
        mem_resp_valid = 1; mem_resp_data = 64'h5A5A_5A5A_5A5A_5A5A;
        tick();
        mem_resp_valid = 0;
        chk("stray_idle_pulse", {62'd0, f_resp_valid, d_resp_valid}, 64'd0);
        chk("stray_idle_busy", {63'd0, busy}, 64'd0);

        // Reset during ISSUE abandons the transaction
        d_req_valid = 1; d_req_addr = 64'h2018; d_req_write = 0;
        do_accept("rst_mid", 0, 0, 64'd0);
        d_req_valid = 0;
        chk("rst_mid_issue", {63'd0, mem_req_valid}, 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst_mid_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        mem_resp_valid = 1; mem_resp_data = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        mem_resp_valid = 0;
        tick();
        chk("rst_late_pulse", {62'd0, f_resp_valid, d_resp_valid}, 64'd0);
        chk("rst_late_busy", {63'd0, busy}, 64'd0);

        // Normal operation after reset
        d_req_valid = 1; d_req_addr = 64'h2020; d_req_write = 0;
        do_accept("post_rst", 0, 1, 64'h0F0F_0F0F_1234_5678);
        d_req_valid = 0;
        serve(64'h2020, 0, 0, 0, 0, 0, 64'h0F0F_0F0F_1234_5678, 0, 0);
        tick();
        tick();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
